// File: rtl/trig_align_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel trigger aligner.
// Channel state encoding plus the pending-queue width rule (never narrower than 1 bit).
package trig_align_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ch_state_t;

  localparam int DEF_MAX_PENDING = 3;

  function automatic int pend_width(input int max_pending);
    return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
  endfunction

  localparam int PEND_W = pend_width(DEF_MAX_PENDING);

endpackage

// File: rtl/trig_align_multi_if.sv
// Sample stream, trigger and status bundle of trig_align_multi; master = stream source/consumer,
// slave = aligner. No backpressure: every s_valid beat is accepted.
interface trig_align_multi_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_CH        = 4,
  parameter int DELAY_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_valid;
  logic [DELAY_WIDTH-1:0] delay;
  logic [N_CH-1:0]        trig_in;
  logic                   clear_overflow;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic [N_CH-1:0]        trig_out;
  logic [N_CH-1:0]        ready;
  logic [N_CH-1:0]        overflow;

  modport master (
    output s_data, s_valid, delay, trig_in, clear_overflow,
    input  m_data, m_valid, trig_out, ready, overflow
  );

  modport slave (
    input  s_data, s_valid, delay, trig_in, clear_overflow,
    output m_data, m_valid, trig_out, ready, overflow
  );
endinterface

// File: rtl/trig_align_multi_channel.sv
// One trigger channel: holds a trigger for delay+1 valid beats, then pulses trig_out for one cycle.
// Latency 1 cycle from the firing beat; no backpressure, extra triggers queue in a saturating counter.
module trig_align_channel
  import trig_align_pkg::*;
#(
  parameter int DELAY_WIDTH = 16,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  parameter bit EDGE        = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic                   trig_in,
  input  logic                   s_valid,
  input  logic                   clear_overflow,
  output logic                   trig_out,
  output logic                   ready,
  output logic                   overflow
);

  localparam int             PW       = pend_width(MAX_PENDING);
  localparam logic [PW-1:0]  PEND_MAX = PW'(MAX_PENDING);

  ch_state_t              state, state_d;
  logic [DELAY_WIDTH-1:0] cnt, cnt_d;
  logic [PW-1:0]          pending, pending_d;
  logic                   trig_q;
  logic                   t_ev;
  logic                   fire;
  logic                   ovf_set;
  logic                   overflow_d;

  assign t_ev  = EDGE ? (trig_in & ~trig_q) : trig_in;
  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      trig_q   <= 1'b0;
      trig_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pending  <= pending_d;
      trig_q   <= trig_in;
      trig_out <= fire;
      overflow <= overflow_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pending_d = pending;
    fire      = 1'b0;
    ovf_set   = 1'b0;

    unique case (state)
      IDLE: begin
        // The event-cycle beat is deliberately not counted: cnt only starts next cycle.
        if (t_ev) begin
          cnt_d   = delay;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s_valid) begin
          if (cnt != '0) cnt_d = cnt - DELAY_WIDTH'(1);
          else           fire  = 1'b1;
        end
        if (fire) begin
          if (pending != '0) begin
            cnt_d = delay;
            if (!t_ev) pending_d = pending - PW'(1);
          end else if (t_ev) begin
            cnt_d = delay;
          end else begin
            state_d = IDLE;
          end
        end else if (t_ev) begin
          if (pending < PEND_MAX) pending_d = pending + PW'(1);
          else                    ovf_set   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new loss in the same cycle as a clear keeps the flag set.
    if (ovf_set)             overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
    else                     overflow_d = overflow;
  end

endmodule

// File: rtl/trig_align_multi.sv
// N_CH independent trigger aligners sharing one sample stream, plus the 1-cycle data register.
// Data latency exactly 1 cycle, trig_out aligned with the firing beat on m_*; no backpressure.
module trig_align_multi
  import trig_align_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N_CH        = 4,
  parameter int DELAY_WIDTH = 16,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  parameter bit EDGE        = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  trig_align_multi_if.slave bus
);

  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic [N_CH-1:0]       trig_out_w;
  logic [N_CH-1:0]       ready_w;
  logic [N_CH-1:0]       overflow_w;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      m_data_q  <= bus.s_data;
      m_valid_q <= bus.s_valid;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    trig_align_channel #(
      .DELAY_WIDTH (DELAY_WIDTH),
      .MAX_PENDING (MAX_PENDING),
      .EDGE        (EDGE)
    ) u_ch (
      .clk            (clk),
      .resetn         (resetn),
      .delay          (bus.delay),
      .trig_in        (bus.trig_in[g]),
      .s_valid        (bus.s_valid),
      .clear_overflow (bus.clear_overflow),
      .trig_out       (trig_out_w[g]),
      .ready          (ready_w[g]),
      .overflow       (overflow_w[g])
    );
  end

  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.trig_out = trig_out_w;
  assign bus.ready    = ready_w;
  assign bus.overflow = overflow_w;

endmodule

// File: tb/tb_trig_align_multi.sv
// Drives an edge-mode and a level-mode trig_align_multi from the same stimulus and compares
// both against a beats-remaining reference model every cycle.
module tb_trig_align_multi;
  import trig_align_pkg::*;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int DLW = 16;
  localparam int MP  = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [DW-1:0]  s_data;
  logic           s_valid;
  logic [DLW-1:0] delay;
  logic [N-1:0]   trig_in;
  logic           clear_ovf;

  trig_align_multi_if #(.DATA_WIDTH(DW), .N_CH(N), .DELAY_WIDTH(DLW)) bus_e ();
  trig_align_multi_if #(.DATA_WIDTH(DW), .N_CH(N), .DELAY_WIDTH(DLW)) bus_l ();

  assign bus_e.s_data = s_data;   assign bus_l.s_data = s_data;
  assign bus_e.s_valid = s_valid; assign bus_l.s_valid = s_valid;
  assign bus_e.delay = delay;     assign bus_l.delay = delay;
  assign bus_e.trig_in = trig_in; assign bus_l.trig_in = trig_in;
  assign bus_e.clear_overflow = clear_ovf;
  assign bus_l.clear_overflow = clear_ovf;

  trig_align_multi #(.DATA_WIDTH(DW), .N_CH(N), .DELAY_WIDTH(DLW), .MAX_PENDING(MP), .EDGE(1'b1))
    u_dut_edge (.clk(clk), .resetn(resetn), .bus(bus_e));
  trig_align_multi #(.DATA_WIDTH(DW), .N_CH(N), .DELAY_WIDTH(DLW), .MAX_PENDING(MP), .EDGE(1'b0))
    u_dut_level (.clk(clk), .resetn(resetn), .bus(bus_l));

  // Reference model, index 0 = edge DUT, 1 = level DUT. need = valid beats still required to fire.
  bit      m_busy [2][N];
  int      m_need [2][N];
  int      m_pend [2][N];
  bit      m_ovf  [2][N];
  bit      m_prev [2][N];
  bit      m_fire [2][N];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  int      obs_pulses [2][N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        m_busy[d][c] = 0; m_need[d][c] = 0; m_pend[d][c] = 0;
        m_ovf[d][c]  = 0; m_prev[d][c] = 0; m_fire[d][c] = 0;
      end
    exp_data  = '0;
    exp_valid = 1'b0;
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        bit ev, f, ovf_set;
        ev = (d == 0) ? (trig_in[c] && !m_prev[d][c]) : trig_in[c];
        m_prev[d][c] = trig_in[c];
        f = 0; ovf_set = 0;
        if (!m_busy[d][c]) begin
          if (ev) begin m_busy[d][c] = 1; m_need[d][c] = int'(delay) + 1; end
        end else begin
          if (s_valid) begin
            m_need[d][c]--;
            f = (m_need[d][c] == 0);
          end
          if (f) begin
            if (m_pend[d][c] > 0) begin
              m_need[d][c] = int'(delay) + 1;
              if (!ev) m_pend[d][c]--;
            end else if (ev) m_need[d][c] = int'(delay) + 1;
            else m_busy[d][c] = 0;
          end else if (ev) begin
            if (m_pend[d][c] < MP) m_pend[d][c]++;
            else ovf_set = 1;
          end
        end
        if (ovf_set) m_ovf[d][c] = 1;
        else if (clear_ovf) m_ovf[d][c] = 0;
        m_fire[d][c] = f;
      end
    exp_data  = s_data;
    exp_valid = s_valid;
  endtask

  task automatic check_all();
    check("edge_m_data", bus_e.m_data, exp_data);
    check("edge_m_valid", bus_e.m_valid, exp_valid);
    check("level_m_data", bus_l.m_data, exp_data);
    check("level_m_valid", bus_l.m_valid, exp_valid);
    for (int c = 0; c < N; c++) begin
      check($sformatf("edge_trig_out[%0d]", c), bus_e.trig_out[c], m_fire[0][c]);
      check($sformatf("edge_ready[%0d]", c), bus_e.ready[c], !m_busy[0][c]);
      check($sformatf("edge_overflow[%0d]", c), bus_e.overflow[c], m_ovf[0][c]);
      check($sformatf("level_trig_out[%0d]", c), bus_l.trig_out[c], m_fire[1][c]);
      check($sformatf("level_ready[%0d]", c), bus_l.ready[c], !m_busy[1][c]);
      check($sformatf("level_overflow[%0d]", c), bus_l.overflow[c], m_ovf[1][c]);
      if (bus_e.trig_out[c] === 1'b1) obs_pulses[0][c]++;
      if (bus_l.trig_out[c] === 1'b1) obs_pulses[1][c]++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [N-1:0] t, input logic v, input logic c);
    trig_in   = t;
    s_valid   = v;
    clear_ovf = c;
    s_data    = $urandom;
    step();
  endtask

  int base_e, base_l;
  logic [DW-1:0] sd;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) obs_pulses[d][c] = 0;
    resetn = 1'b0; s_data = '0; s_valid = 1'b0; delay = '0; trig_in = '0; clear_ovf = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;

    // 1: delay 0, single trigger, first valid beat three cycles later fires
    delay = 16'd0;
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    check("s1_pulse_with_m_valid", bus_e.trig_out[0] & bus_e.m_valid, 1);
    drive(4'b0000, 1'b0, 1'b0);
    check("s1_ready_back", bus_e.ready[0], 1);

    // 2: delay 3, valid toggling 1010..., fire on the 4th valid beat
    delay = 16'd3;
    drive(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(4'b0000, (i % 2) == 0, 1'b0);
      if (i == 6) begin
        sd = s_data;
        check("s2_pulse", bus_e.trig_out[1], 1);
        check("s2_aligned_data", bus_e.m_data, sd);
      end
    end

    // 3: five triggers while the channel waits with no valid beats
    delay = 16'd2;
    base_e = obs_pulses[0][2]; base_l = obs_pulses[1][2];
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0, 1'b0);
      drive(4'b0000, 1'b0, 1'b0);
    end
    check("s3_overflow_edge", bus_e.overflow[2], 1);
    check("s3_overflow_level", bus_l.overflow[2], 1);
    repeat (20) drive(4'b0000, 1'b1, 1'b0);
    check("s3_pulses_edge", obs_pulses[0][2] - base_e, 4);
    check("s3_pulses_level", obs_pulses[1][2] - base_l, 4);
    drive(4'b0000, 1'b0, 1'b1);

    // 4: new trigger exactly in the firing cycle with an empty queue
    delay = 16'd1;
    base_e = obs_pulses[0][3];
    drive(4'b1000, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b1000, 1'b1, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    check("s4_two_pulses", obs_pulses[0][3] - base_e, 2);
    check("s4_no_overflow", bus_e.overflow[3], 0);

    // 5: trigger held high for 20 cycles
    base_e = obs_pulses[0][0];
    repeat (20) drive(4'b0001, 1'b0, 1'b0);
    check("s5_level_overflow", bus_l.overflow[0], 1);
    check("s5_edge_no_overflow", bus_e.overflow[0], 0);
    repeat (30) drive(4'b0000, 1'b1, 1'b0);
    check("s5_edge_single_pulse", obs_pulses[0][0] - base_e, 1);
    drive(4'b0000, 1'b0, 1'b1);

    // 6: reset while waiting with cnt=2 and one queued trigger
    delay = 16'd5;
    drive(4'b0010, 1'b0, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    base_e = obs_pulses[0][1]; base_l = obs_pulses[1][1];
    repeat (12) drive(4'b0000, 1'b1, 1'b0);
    check("s6_no_late_pulse_edge", obs_pulses[0][1] - base_e, 0);
    check("s6_no_late_pulse_level", obs_pulses[1][1] - base_l, 0);
    check("s6_ready", bus_e.ready[1], 1);

    // Randomised traffic: sparse triggers, changing delay, random valid and clears
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] t;
      if ($urandom_range(0, 15) == 0) delay = DLW'($urandom_range(0, 4));
      for (int c = 0; c < N; c++) t[c] = ($urandom_range(0, 7) == 0);
      drive(t, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
